// File: rtl/sha3_absorb_ctrl.sv
// SHA-3 absorb/squeeze controller.
// Splits an AXI-Stream message into rate-sized lanes for the rate buffer,
// zero-fills the tail of the final block, starts the Keccak permutation and
// streams the digest lanes back out. Padding itself is done downstream; this
// block only signals which permutation carries the final (padded) block.
module sha3_absorb_ctrl #(
  parameter int DW = 64
) (
  input  logic          ACLK,
  input  logic          ARESET,
  // message stream
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tlast,
  input  logic [1:0]    s_axis_tuser,
  // rate buffer write port
  output logic          blk_we,
  output logic [4:0]    blk_idx,
  output logic [DW-1:0] blk_wdata,
  // padding stage / permutation core
  output logic          pad_last,
  output logic [1:0]    pad_mode,
  output logic          perm_start,
  input  logic          perm_done,
  // digest read port
  output logic [2:0]    dig_rd_idx,
  input  logic [DW-1:0] dig_rdata,
  // digest stream
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_ZFILL,
    ST_PERM,
    ST_WAIT,
    ST_SQUEEZE
  } state_t;

  // Index of the last rate lane (R-1) for each mode: R = 18, 17, 13, 9.
  function automatic logic [4:0] rate_last(input logic [1:0] mode);
    case (mode)
      2'd0:    return 5'd17;
      2'd1:    return 5'd16;
      2'd2:    return 5'd12;
      default: return 5'd8;
    endcase
  endfunction

  // Index of the last digest lane (L-1) for each mode: L = 4, 4, 6, 8.
  function automatic logic [2:0] dig_last(input logic [1:0] mode);
    case (mode)
      2'd0:    return 3'd3;
      2'd1:    return 3'd3;
      2'd2:    return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] didx_q, didx_d;
  logic       last_msg_q, last_msg_d;
  logic       extra_blk_q, extra_blk_d;
  logic [1:0] mode_q, mode_d;

  // Mode in force this cycle: in IDLE the incoming beat defines it.
  logic [1:0] mode_cur;
  logic [4:0] r_last;

  assign mode_cur = (state_q == ST_IDLE) ? s_axis_tuser : mode_q;
  assign r_last   = rate_last(mode_cur);

  // State register with synchronous reset.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments here so every flop samples the values of
    // the previous cycle regardless of statement order.
    if (ARESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      didx_q      <= '0;
      last_msg_q  <= 1'b0;
      extra_blk_q <= 1'b0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      didx_q      <= didx_d;
      last_msg_q  <= last_msg_d;
      extra_blk_q <= extra_blk_d;
      mode_q      <= mode_d;
    end
  end

  // Next-state and output decode; everything stays at zero while in reset.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    didx_d        = didx_q;
    last_msg_d    = last_msg_q;
    extra_blk_d   = extra_blk_q;
    mode_d        = mode_q;
    s_axis_tready = 1'b0;
    blk_we        = 1'b0;
    blk_idx       = '0;
    blk_wdata     = '0;
    pad_last      = 1'b0;
    pad_mode      = '0;
    perm_start    = 1'b0;
    dig_rd_idx    = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b0;

    if (!ARESET) begin
      busy     = (state_q != ST_IDLE);
      pad_mode = mode_q;

      case (state_q)
        ST_IDLE: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            // First lane of every message always lands at index 0.
            blk_we    = 1'b1;
            blk_idx   = 5'd0;
            blk_wdata = s_axis_tdata;
            mode_d    = s_axis_tuser;
            cnt_d     = 5'd1;
            if (s_axis_tlast) begin
              // Every rate is larger than one lane, so a one-word message
              // always needs zero fill.
              last_msg_d = 1'b1;
              state_d    = ST_ZFILL;
            end else begin
              state_d = ST_ABSORB;
            end
          end
        end

        ST_ABSORB: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            blk_we    = 1'b1;
            blk_idx   = cnt_q;
            blk_wdata = s_axis_tdata;
            cnt_d     = cnt_q + 5'd1;
            if (cnt_q == r_last) begin
              // Block full. If the message also ends here, this block goes
              // out unpadded and an all-zero padded block follows.
              if (s_axis_tlast) extra_blk_d = 1'b1;
              state_d = ST_PERM;
            end else if (s_axis_tlast) begin
              last_msg_d = 1'b1;
              state_d    = ST_ZFILL;
            end
          end
        end

        ST_ZFILL: begin
          blk_we    = 1'b1;
          blk_idx   = cnt_q;
          blk_wdata = '0;
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == r_last) state_d = ST_PERM;
        end

        ST_PERM: begin
          perm_start = 1'b1;
          pad_last   = last_msg_q;
          state_d    = ST_WAIT;
        end

        ST_WAIT: begin
          if (perm_done) begin
            if (extra_blk_q) begin
              extra_blk_d = 1'b0;
              last_msg_d  = 1'b1;
              cnt_d       = 5'd0;
              state_d     = ST_ZFILL;
            end else if (last_msg_q) begin
              didx_d  = 3'd0;
              state_d = ST_SQUEEZE;
            end else begin
              cnt_d   = 5'd0;
              state_d = ST_ABSORB;
            end
          end
        end

        ST_SQUEEZE: begin
          // Data comes straight from the digest lane selected by didx, so it
          // holds steady for as long as didx does.
          m_axis_tvalid = 1'b1;
          dig_rd_idx    = didx_q;
          m_axis_tdata  = dig_rdata;
          m_axis_tlast  = (didx_q == dig_last(mode_q));
          if (m_axis_tready) begin
            didx_d = didx_q + 3'd1;
            if (didx_q == dig_last(mode_q)) begin
              last_msg_d = 1'b0;
              cnt_d      = 5'd0;
              state_d    = ST_IDLE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Directed bench for sha3_absorb_ctrl: a table of whole messages is driven
// through a cycle-accurate scoreboard, plus hand sequences for reset cases.
module tb_sha3_absorb_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic [1:0]  s_axis_tuser;
  logic        blk_we;
  logic [4:0]  blk_idx;
  logic [63:0] blk_wdata;
  logic        pad_last;
  logic [1:0]  pad_mode;
  logic        perm_start;
  logic        perm_done;
  logic [2:0]  dig_rd_idx;
  logic [63:0] dig_rdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  sha3_absorb_ctrl #(.DW(64)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .blk_we        (blk_we),
    .blk_idx       (blk_idx),
    .blk_wdata     (blk_wdata),
    .pad_last      (pad_last),
    .pad_mode      (pad_mode),
    .perm_start    (perm_start),
    .perm_done     (perm_done),
    .dig_rd_idx    (dig_rd_idx),
    .dig_rdata     (dig_rdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  always #5 ACLK = ~ACLK;

  // Digest store stand-in: each lane carries its own index in the low bits.
  assign dig_rdata = {56'h0123456789ABCD, 5'd0, dig_rd_idx};

  function automatic logic [63:0] digest_lane(input int i);
    return {56'h0123456789ABCD, 5'd0, 3'(i)};
  endfunction

  function automatic logic [63:0] msg_word(input int id, input int w);
    return {32'hCAFE_0000 + 32'(id), 32'(w)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rate in words per mode.
  int rate_tab [4] = '{18, 17, 13, 9};

  typedef struct {
    logic [1:0] mode;
    int         n_words;
    int         exp_perms;  // permutations started
    int         exp_zeros;  // zero-fill lane writes
    int         exp_beats;  // digest beats
    logic [3:0] rdy_pat;    // m_axis_tready pattern, bit 0 first
    int         stray_w;    // inject a stray perm_done while offering this word (-1: none)
  } vec_t;

  vec_t vecs [8];

  // Drive one message end to end and score every cycle against the vector.
  task automatic run_msg(input vec_t v, input int id);
    int          w = 0, exp_idx = 0, perms = 0, zeros = 0, datas = 0;
    int          beats = 0, cd = 0, cyc = 0, sq_i = 0;
    bit          stray_used = 0, held = 0, done = 0;
    logic [63:0] held_data = '0;
    while (!done && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
      s_axis_tvalid = (w < v.n_words);
      s_axis_tdata  = msg_word(id, w);
      s_axis_tlast  = (w == v.n_words - 1);
      s_axis_tuser  = (w == 0) ? v.mode : ~v.mode;
      perm_done     = 1'b0;
      if (cd == 1) perm_done = 1'b1;
      else if (cd == 0 && !stray_used && w == v.stray_w) begin
        perm_done  = 1'b1;
        stray_used = 1'b1;
      end
      if (cd > 0) cd--;
      m_axis_tready = v.rdy_pat[sq_i % 4];
      #1;
      if (held) begin
        check("sq_hold_valid", m_axis_tvalid, 1'b1);
        check("sq_hold_data", m_axis_tdata, held_data);
      end
      held = 0;
      if (blk_we) begin
        check("blk_idx", blk_idx, exp_idx);
        if (s_axis_tvalid && s_axis_tready) begin
          check("blk_wdata", blk_wdata, msg_word(id, w));
          datas++;
        end else begin
          check("zfill_data", blk_wdata, 64'd0);
          zeros++;
        end
        exp_idx++;
      end
      if (perm_start) begin
        check("perm_block_full", exp_idx, rate_tab[v.mode]);
        check("pad_last", pad_last, (perms == v.exp_perms - 1));
        check("pad_mode", pad_mode, v.mode);
        perms++;
        exp_idx = 0;
        cd      = 3;
      end
      if (m_axis_tvalid) begin
        check("sq_tdata", m_axis_tdata, digest_lane(beats));
        check("sq_tlast", m_axis_tlast, (beats == v.exp_beats - 1));
        if (m_axis_tready) begin
          beats++;
          if (beats == v.exp_beats) done = 1;
        end else begin
          held      = 1;
          held_data = m_axis_tdata;
        end
        sq_i++;
      end
      if (s_axis_tvalid && s_axis_tready) w++;
    end
    check("msg_done", done, 1'b1);
    check("data_writes", datas, v.n_words);
    check("zero_writes", zeros, v.exp_zeros);
    check("perm_count", perms, v.exp_perms);
    @(negedge ACLK);
    s_axis_tvalid = 1'b0;
    perm_done     = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_tvalid", m_axis_tvalid, 1'b0);
    check("idle_tready", s_axis_tready, 1'b1);
  endtask

  initial begin
    vec_t v0;
    bit   seen;
    //         mode  words perms zeros beats rdy      stray
    vecs[0] = '{2'd1,  3,    1,    14,   4,  4'b1111, -1};
    vecs[1] = '{2'd3,  9,    2,     9,   8,  4'b1111, -1};
    vecs[2] = '{2'd2, 20,    2,     6,   6,  4'b1111,  2};
    vecs[3] = '{2'd0,  1,    1,    17,   4,  4'b1001, -1};
    vecs[4] = '{2'd0, 18,    2,    18,   4,  4'b1111, -1};
    vecs[5] = '{2'd1, 22,    2,    12,   4,  4'b1001, -1};
    vecs[6] = '{2'd2, 12,    1,     1,   6,  4'b0110, -1};
    vecs[7] = '{2'd3,  8,    1,     1,   8,  4'b1111, -1};

    // Reset with a live beat offered: nothing may be accepted or driven.
    ARESET        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'hDEAD_BEEF;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 2'd2;
    perm_done     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_blk_we", blk_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_perm_start", perm_start, 1'b0);
    check("rst_pad_mode", pad_mode, 2'd0);
    @(negedge ACLK);
    ARESET        = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("post_rst_tready", s_axis_tready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) run_msg(vecs[i], i);

    // Reset while waiting on the permutation; the late done must be dropped.
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge ACLK);
      s_axis_tvalid = !busy;
      s_axis_tdata  = 64'h1111;
      s_axis_tlast  = 1'b1;
      s_axis_tuser  = 2'd2;
      #1;
      if (perm_start) seen = 1;
    end
    check("wait_reached", seen, 1'b1);
    @(negedge ACLK);
    s_axis_tvalid = 1'b0;
    ARESET        = 1'b1;
    #1;
    check("wait_rst_busy", busy, 1'b0);
    check("wait_rst_tready", s_axis_tready, 1'b0);
    @(negedge ACLK);
    ARESET    = 1'b0;
    perm_done = 1'b1;
    #1;
    check("late_done_busy", busy, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      perm_done = 1'b0;
      #1;
      check("late_done_tvalid", m_axis_tvalid, 1'b0);
      check("late_done_idle", busy, 1'b0);
      check("late_done_start", perm_start, 1'b0);
    end
    v0 = '{2'd0, 1, 1, 17, 4, 4'b1111, -1};
    run_msg(v0, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_absorb_ctrl.md
SHA3_ABSORB_CTRL -- requirements
Module: sha3_absorb_ctrl

Interface
REQ-001 Parameter DW, default 64: stream and lane word width; only the value 64 is supported.
REQ-002 ACLK  in  1  single clock; all state changes on its rising edge.
REQ-003 ARESET  in  1  reset, synchronous and active-high.
REQ-004 s_axis_tvalid  in  1  message word valid.
REQ-005 s_axis_tready  out  1  controller accepts a message word.
REQ-006 s_axis_tdata  in  DW  message word.
REQ-007 s_axis_tlast  in  1  final word of the message.
REQ-008 s_axis_tuser  in  2  mode: 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
REQ-009 blk_we  out  1  write strobe into the rate buffer.
REQ-010 blk_idx  out  5  rate-buffer lane index.
REQ-011 blk_wdata  out  DW  lane data.
REQ-012 pad_last  out  1  drives TLAST of the padding stage.
REQ-013 pad_mode  out  2  drives TUSER of the padding stage.
REQ-014 perm_start  out  1  one-cycle Keccak permutation start.
REQ-015 perm_done  in  1  one-cycle permutation complete pulse.
REQ-016 dig_rd_idx  out  3  digest lane select.
REQ-017 dig_rdata  in  DW  digest lane, combinational from dig_rd_idx.
REQ-018 m_axis_tvalid, m_axis_tready, m_axis_tdata[DW], m_axis_tlast  out/in/out/out  digest stream.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The controller SHALL use the states IDLE, ABSORB, ZFILL, PERM, WAIT and SQUEEZE.
REQ-021 Rate R in words SHALL be 18, 17, 13 or 9, and digest length L in words SHALL be 4, 4, 6 or 8, for modes 0, 1, 2 and 3 respectively.
REQ-022 Mode SHALL be latched from s_axis_tuser on the first accepted beat of a message; tuser on later beats SHALL be ignored; pad_mode SHALL output the latched mode.
REQ-023 s_axis_tready SHALL be 1 only in IDLE and ABSORB.
REQ-024 Each accepted beat SHALL produce, in the same cycle, blk_we=1, blk_idx=cnt and blk_wdata=tdata, then increment cnt.
REQ-025 IDLE, beat accepted: latch mode, cnt<=1, go to ABSORB.
REQ-026 IDLE, beat accepted with tlast and R>1: set last_msg and go to ZFILL.
REQ-027 ABSORB, beat accepted, cnt+1<R, no tlast: stay in ABSORB.
REQ-028 ABSORB, beat with tlast and cnt+1<R: set last_msg, go to ZFILL.
REQ-029 ABSORB, beat with cnt+1==R, no tlast: go to PERM.
REQ-030 ABSORB, beat with cnt+1==R and tlast: set extra_blk, go to PERM; that block SHALL be permuted without padding, then one all-zero block (ZFILL from cnt=0) SHALL follow with padding.
REQ-031 ZFILL SHALL write blk_wdata=0 at blk_idx=cnt, one lane per cycle, up to and including R-1, then go to PERM.
REQ-032 PERM SHALL last exactly one cycle with perm_start=1, and pad_last=1 only if last_msg is set, then go to WAIT.
REQ-033 WAIT SHALL ignore all stream input; perm_done SHALL be sampled only in WAIT, and a pulse in any other state SHALL be dropped.
REQ-034 WAIT + perm_done, with extra_blk set: clear extra_blk, set last_msg, cnt<=0, go to ZFILL.
REQ-035 WAIT + perm_done, with last_msg set: didx<=0, go to SQUEEZE.
REQ-036 WAIT + perm_done, otherwise: cnt<=0, go to ABSORB.
REQ-037 In SQUEEZE, m_axis_tvalid=1, dig_rd_idx=didx, m_axis_tdata=dig_rdata, and m_axis_tlast=(didx==L-1).
REQ-038 In SQUEEZE, tvalid and tdata SHALL be held stable while tready=0.
REQ-039 In SQUEEZE, each handshake SHALL increment didx; the handshake on didx==L-1 SHALL clear last_msg and return to IDLE.
REQ-040 Throughput: one lane per cycle in ABSORB and ZFILL; the permutation overhead SHALL be 1 cycle plus the core latency.

Reset
REQ-041 While ARESET=1, the next state SHALL be IDLE, and cnt, didx, last_msg, extra_blk and the latched mode SHALL be 0.
REQ-042 All outputs SHALL be 0 during reset, including s_axis_tready; s_axis_tready SHALL be 1 from the first IDLE cycle after reset.
REQ-043 Reset asserted mid-message or mid-squeeze SHALL abandon the transfer with no further blk_we, perm_start or m_axis beat.

Verification
REQ-044 Mode 1, 3-word message (tlast on word 3) -> writes at idx 0..2 with data, zero lanes at idx 3..16, one perm_start with pad_last=1, then 4 digest beats, tlast on beat 4.
REQ-045 Mode 3, 9 words, tlast on word 9 -> block 1: perm_start with pad_last=0; after perm_done, 9 zero writes (idx 0..8), perm_start with pad_last=1; then 8 digest beats.
REQ-046 Mode 2, 20 words -> perm_start after word 13 with pad_last=0; word 14 written at idx 0; zero fill at idx 7..12; second perm_start with pad_last=1; 6 digest beats.
REQ-047 m_axis_tready toggled 1,0,0,1 during SQUEEZE -> tdata stable while stalled, no lane skipped or repeated, busy=0 after the final beat.
REQ-048 ARESET pulsed in WAIT, and perm_done arriving afterwards -> stays IDLE with no m_axis_tvalid; a subsequent 1-word mode-0 message completes normally.
REQ-049 perm_done pulsed in ABSORB -> ignored, with no state change.
